// File: rtl/violation_event_logger.sv
// violation_event_logger: mode-gated violation detector with timestamped FWFT event FIFO.
// Define VIOL_LOGGER_EDGE_ONLY_EN to detect only rising edges of chk_sig.
module violation_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_sig,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic [1:0]       mode,
  output logic             viol_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] viol_count,
  output logic             overflow,
  input  logic             ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, FROZEN = 2'b10} mode_t;
  mode_t state, state_nx, saved, saved_nx;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic detect, empty, full, pop, push, drop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= OFF;
      saved <= OFF;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
    end
  always_comb begin
    state_nx = state;
    saved_nx = saved;
    if (cmd_valid)
      case (cmd_code)
        2'b00: begin
          state_nx = OFF;
          saved_nx = OFF;
        end
        2'b01: state_nx = ON;
        2'b10: begin
          state_nx = FROZEN;
          saved_nx = (state == FROZEN) ? saved : state;
        end
        default: state_nx = (state == FROZEN) ? saved : state;
      endcase
  end
`ifdef VIOL_LOGGER_EDGE_ONLY_EN
  logic chk_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_prev <= 1'b0;
    else        chk_prev <= chk_sig;
  assign detect = (state == ON) && chk_sig && !chk_prev;
`else
  assign detect = (state == ON) && chk_sig;
`endif
  assign mode  = state;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && evt_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push  = detect && (!full || pop);
  assign drop  = detect && full && !pop;
  assign evt_valid = !empty;
  assign evt_ts    = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= ts;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts         <= '0;
      wptr       <= '0;
      rptr       <= '0;
      viol_pulse <= 1'b0;
      viol_count <= '0;
      overflow   <= 1'b0;
    end else begin
      ts         <= (state == FROZEN) ? ts : ts + TS_W'(1);
      wptr       <= push ? wptr + (AW+1)'(1) : wptr;
      rptr       <= pop ? rptr + (AW+1)'(1) : rptr;
      viol_pulse <= detect;
      viol_count <= (detect && viol_count != '1) ? viol_count + CNT_W'(1) : viol_count;
      overflow   <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
endmodule

// File: tb/tb_violation_event_logger.sv
// tb_violation_event_logger: directed self-checking bench for violation_event_logger (edge-only build off).
module tb_violation_event_logger;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic chk_sig = 1'b0, cmd_valid = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
  logic [1:0] cmd_code = 2'b00;
  logic [1:0] mode;
  logic viol_pulse, evt_valid, overflow;
  logic [15:0] evt_ts;
  logic [7:0] viol_count;
  int n_chk = 0, n_err = 0;
  logic [1:0] m_mode = 2'b00, m_saved = 2'b00;
  logic [15:0] m_ts = '0;
  logic [15:0] t0, last;
  int n;

  violation_event_logger #(.DEPTH(DEPTH), .TS_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .chk_sig(chk_sig), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .mode(mode), .viol_pulse(viol_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts),
    .viol_count(viol_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one cycle; the reference timestamp/mode update with the pre-edge mode
  task automatic step();
    @(posedge clk);
    if (m_mode != 2'b10) m_ts = m_ts + 16'd1;
    if (cmd_valid)
      case (cmd_code)
        2'b00: begin m_mode = 2'b00; m_saved = 2'b00; end
        2'b01: m_mode = 2'b01;
        2'b10: if (m_mode != 2'b10) begin m_saved = m_mode; m_mode = 2'b10; end
        default: if (m_mode == 2'b10) m_mode = m_saved;
      endcase
    @(negedge clk);
  endtask

  task automatic cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd_code = c;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk_sig = 1'b0; cmd_valid = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 2'b00; m_saved = 2'b00; m_ts = '0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_ts", evt_ts, 0);
    check("rst_pulse", viol_pulse, 0);
    check("rst_count", viol_count, 0);
    check("rst_ovf", overflow, 0);
    do_reset();
    // 1: OFF held, chk high
    cmd_valid = 1'b1; cmd_code = 2'b00; chk_sig = 1'b1;
    repeat (5) step();
    cmd_valid = 1'b0; chk_sig = 1'b0;
    check("off_count", viol_count, 0);
    check("off_valid", evt_valid, 0);
    check("off_mode", mode, 0);
    // 2: single violation at timestamp 12
    cmd(2'b01);
    check("on_mode", mode, 1);
    n = 0;
    while (m_ts != 16'd12 && n < 20) begin step(); n++; end
    chk_sig = 1'b1;
    step();
    chk_sig = 1'b0;
    check("v1_pulse", viol_pulse, 1);
    check("v1_valid", evt_valid, 1);
    check("v1_ts", evt_ts, 12);
    check("v1_count", viol_count, 1);
    step();
    check("v1_pulse_end", viol_pulse, 0);
    check("hold_valid", evt_valid, 1);
    check("hold_ts", evt_ts, 12);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("v1_popped", evt_valid, 0);
    // 3: freeze from ON, thaw, then verify timestamp held while frozen
    cmd(2'b10);
    check("frz_mode", mode, 2);
    chk_sig = 1'b1;
    repeat (4) step();
    chk_sig = 1'b0;
    check("frz_count", viol_count, 1);
    check("frz_valid", evt_valid, 0);
    cmd(2'b11);
    check("thaw_on", mode, 1);
    t0 = m_ts;
    chk_sig = 1'b1;
    step();
    chk_sig = 1'b0;
    check("frz_ts_held", evt_ts, t0);
    check("frz_count2", viol_count, 2);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    cmd(2'b00);
    cmd(2'b10);
    check("frz_from_off", mode, 2);
    cmd(2'b10);
    cmd(2'b11);
    check("thaw_off", mode, 0);
    cmd(2'b11);
    check("thaw_ignored", mode, 0);
    // 4: overflow with DEPTH+2 violations, then drain
    do_reset();
    cmd(2'b01);
    t0 = m_ts;
    chk_sig = 1'b1;
    repeat (DEPTH) step();
    check("fill_ovf", overflow, 0);
    step();
    check("drop_ovf", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk_sig = 1'b0;
    check("set_wins", overflow, 1);
    check("ovf_count", viol_count, 10);
    evt_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", evt_valid, 1);
      check("drain_ts", evt_ts, t0 + 16'(i));
      step();
    end
    evt_ready = 1'b0;
    check("drain_empty", evt_valid, 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    // 5: push and pop together while full
    t0 = m_ts;
    chk_sig = 1'b1;
    repeat (DEPTH) step();
    evt_ready = 1'b1;
    step();
    chk_sig = 1'b0;
    check("fullpp_ovf", overflow, 0);
    check("fullpp_head", evt_ts, t0 + 16'd1);
    n = 0;
    last = '0;
    while (evt_valid && n < 20) begin last = evt_ts; step(); n++; end
    check("fullpp_n", n, DEPTH);
    check("fullpp_last", last, t0 + 16'(DEPTH));
    check("fullpp_ovf2", overflow, 0);
    // 6: saturation with continuous draining, then async reset mid-stream
    do_reset();
    cmd(2'b01);
    evt_ready = 1'b1;
    chk_sig = 1'b1;
    repeat (300) step();
    check("sat_count", viol_count, 255);
    check("sat_ovf", overflow, 0);
    check("sat_pulse", viol_pulse, 1);
    rst_n = 1'b0;
    #1;
    check("ar_mode", mode, 0);
    check("ar_count", viol_count, 0);
    check("ar_valid", evt_valid, 0);
    check("ar_pulse", viol_pulse, 0);
    check("ar_ts", evt_ts, 0);
    check("ar_ovf", overflow, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/violation_event_logger.md
Name: violation_event_logger

Overview:
Hardware checker stage that sits directly downstream of a monitored control signal (the "must stay low after reset" signal) and applies the team's runtime assertion-control semantics in RTL.
- Modes: off / on / freeze / thaw.
- Each violation is recorded with a cycle timestamp into a small first-word-fall-through (FWFT) event FIFO.
- Firmware or the testbench drains the FIFO over a valid/ready port.
- A saturating violation count and a sticky overflow flag are also kept.

Parameters:
DEPTH, 8, event FIFO entries; power of 2, >= 2.
TS_W, 16, timestamp counter width.
CNT_W, 8, saturating violation counter width.

Ports:
clk  in  1  system clock, all state on posedge.
rst_n  in  1  asynchronous active-low reset.
chk_sig  in  1  monitored signal; a violation is chk_sig==1 sampled while mode is ON.
cmd_valid  in  1  mode command strobe, one cycle.
cmd_code  in  2  00 OFF, 01 ON, 10 FREEZE, 11 THAW.
mode  out  2  current mode: 00 OFF, 01 ON, 10 FROZEN.
viol_pulse  out  1  registered one-cycle pulse per detected violation.
evt_valid  out  1  FIFO non-empty.
evt_ready  in  1  consumer accepts head entry.
evt_ts  out  TS_W  timestamp of head entry; 0 when empty.
viol_count  out  CNT_W  total violations detected, saturating.
overflow  out  1  sticky: a violation was dropped because the FIFO was full.
ovf_clr  in  1  clears overflow.

Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset (async assert, sync release) sets: mode=OFF, saved_mode=OFF, timestamp=0, FIFO empty, evt_valid=0, evt_ts=0, viol_pulse=0, viol_count=0, overflow=0. Reset mid-operation discards all FIFO contents and any in-flight pulse.
- Mode FSM (states OFF, ON, FROZEN). A command takes effect at the clock edge where cmd_valid=1. The sample on that same edge uses the pre-command mode.
  - OFF cmd: go to OFF from any state; saved_mode := OFF.
  - ON cmd: go to ON from any state.
  - FREEZE cmd: from OFF or ON, go to FROZEN and set saved_mode := current mode. In FROZEN it is ignored, so saved_mode is not overwritten.
  - THAW cmd: in FROZEN, go to saved_mode. Ignored in OFF and ON.
- Timestamp counter:
  - Increments by 1 every cycle in OFF and ON; wraps modulo 2^TS_W.
  - Holds its value while FROZEN.
- Detection:
  - At each posedge with mode==ON and chk_sig==1, a violation is detected.
  - The current timestamp is captured and pushed.
  - viol_pulse=1 in the following cycle.
  - viol_count increments, saturating at 2^CNT_W-1.
  - OFF and FROZEN never detect.
- Latency: the FIFO is FWFT. From an empty FIFO, evt_valid=1 and evt_ts are valid in the cycle after the sampling edge (same cycle as viol_pulse).
- Handshake:
  - Pop on evt_valid&&evt_ready.
  - evt_ts and evt_valid must stay stable while evt_valid=1 and evt_ready=0.
  - evt_ready while empty has no effect.
- Full FIFO:
  - A push with no pop in the same cycle is dropped; overflow is set. viol_count and viol_pulse still update.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the push lands; evt_valid=1 next cycle.
- overflow clears on ovf_clr. If a new drop occurs in the same cycle as ovf_clr, set wins.
- Pointers are log2(DEPTH)+1 bits. Full/empty are distinguished by the MSB.

Optional Feature:
Macro: VIOL_LOGGER_EDGE_ONLY_EN
- Defined: a violation is detected only on a rising edge of chk_sig while mode==ON. The previous chk_sig value is registered; it resets to 0 and keeps tracking in every mode. A sustained high produces exactly one event.
- Undefined: every sampled cycle with chk_sig==1 in ON is a separate violation.

Test Plan:
1. Reset, cmd OFF held, chk_sig=1 for 5 cycles -> viol_count=0, evt_valid=0, mode=00.
2. cmd ON, chk_sig=1 for exactly 1 cycle at timestamp 12 -> viol_pulse one cycle, evt_valid=1, evt_ts=12, viol_count=1; evt_ready=1 -> evt_valid=0 next cycle.
3. From ON: FREEZE, chk_sig=1 for 4 cycles, then THAW -> no events, timestamp unchanged across the frozen span, mode returns to 01. Repeat from OFF -> THAW returns to 00.
4. evt_ready=0, DEPTH+2 violations (edge-only undefined) -> 8 entries, overflow=1, viol_count=10. Drain -> timestamps ascending and consecutive. ovf_clr -> overflow=0.
5. FIFO full, chk_sig=1 and evt_ready=1 in the same cycle -> count stays 8, overflow stays 0.
6. CNT_W=8, 300 violations with the FIFO continuously drained -> viol_count=255. Assert rst_n low mid-stream -> all outputs return to reset values immediately.
